instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of instruction words; must be a power of two and at least 4.
REQ-003 SHALL have parameter ADDR_W, default 32: fetch byte-address width.
REQ-004 SHALL have parameter NOP_WORD, default all zeros: word returned on a fault.
REQ-005 clk  in  1  the block's only clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 load_start  in  1  begin (re)programming; clears the write pointer.
REQ-008 load_valid  in  1  load_data is valid this cycle.
REQ-009 load_data  in  DATA_W  instruction word to store at the write pointer.
REQ-010 load_ready  out  1  block can accept a load word.
REQ-011 load_done  in  1  programming finished; enter RUN.
REQ-012 fetch_valid  in  1  fetch request.
REQ-013 fetch_addr  in  ADDR_W  byte address of the fetch.
REQ-014 fetch_ready  out  1  fetch accepted this cycle.
REQ-015 instr_valid  out  1  instruction and addr_fault are valid.
REQ-016 instruction  out  DATA_W  fetched word.
REQ-017 addr_fault  out  1  the accepted fetch was misaligned, out of range, or unloaded.
REQ-018 loaded_count  out  clog2(DEPTH+1)  number of words written since the last load_start.

Function
REQ-019 SHALL implement states IDLE, LOAD and RUN.
REQ-020 SHALL take these transitions: IDLE->LOAD on load_start; LOAD->RUN on load_done; RUN->LOAD on load_start; no other transitions.
REQ-021 load_start asserted in LOAD SHALL restart the load by clearing the write pointer and loaded_count.
REQ-022 load_ready SHALL be 1 only when the state is LOAD, loaded_count < DEPTH, and load_start is 0.
REQ-023 A load word SHALL be written only when load_valid and load_ready are both 1: mem[loaded_count] <= load_data and loaded_count increments by 1, both in the same cycle.
REQ-024 When loaded_count = DEPTH (full), load_valid SHALL be ignored with no write and no wrap-around.
REQ-025 load_valid and load_done together in LOAD SHALL write the word and then enter RUN, with the count including that word.
REQ-026 fetch_ready SHALL equal (state == RUN) AND NOT load_start; load_start takes priority over a simultaneous fetch.
REQ-027 A fetch SHALL be accepted when fetch_valid and fetch_ready are both 1, with the result presented the next cycle (latency 1): instr_valid = 1 for exactly one cycle per accepted fetch.
REQ-028 The word index SHALL be fetch_addr >> 2.
REQ-029 A fetch is a fault if fetch_addr[1:0] != 0, or index >= DEPTH, or index >= loaded_count.
REQ-030 On a fault the response SHALL be instruction = NOP_WORD and addr_fault = 1.
REQ-031 On a non-fault fetch the response SHALL be instruction = mem[index] and addr_fault = 0.
REQ-032 Back-to-back fetches SHALL sustain one response per cycle.
REQ-033 instruction SHALL hold its last value while instr_valid = 0.
REQ-034 fetch_valid outside RUN SHALL be ignored with no response.
REQ-035 A fetch accepted in the same cycle that load_start would be ignored cannot occur, because fetch_ready is 0 in that cycle.

Reset
REQ-036 While rst_n = 0 at a clock edge: state = IDLE, loaded_count = 0, instr_valid = 0, instruction = 0, addr_fault = 0.
REQ-037 Memory contents SHALL NOT be reset; they are unreadable because loaded_count = 0 forces a fault.
REQ-038 Reset mid-load or mid-fetch SHALL abort the operation; no response is produced for an in-flight fetch.

Structure
REQ-039 Package imem_pkg SHALL hold the state enum (IDLE/LOAD/RUN), the default DATA_W and DEPTH, and the NOP_WORD default.
REQ-040 Sub-module imem_array SHALL be a DEPTH x DATA_W memory with one write port and one synchronous read port.
REQ-041 FSM, fault logic and output registers SHALL live in instr_mem_loadable.

Verification
REQ-042 Reset, load_start, load 10 words (addi/sw pairs), load_done, fetch addr 0,4,...,36 back-to-back -> 10 consecutive instr_valid, words match in order, addr_fault = 0.
REQ-043 In RUN with 10 words loaded: fetch 40 -> NOP_WORD with fault; fetch 2 -> fault; fetch 256 (DEPTH 64) -> fault.
REQ-044 Load 64 words, then present 3 extra load_valid -> load_ready = 0, loaded_count stays 64, mem[0] unchanged.
REQ-045 RUN, load_start in the same cycle as fetch_valid -> fetch_ready = 0, no instr_valid next cycle, state = LOAD, loaded_count = 0.
REQ-046 Drive rst_n = 0 for one cycle mid-load after 5 words -> state IDLE, loaded_count 0; fetch of addr 0 is ignored until a reload completes.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and defaults for the loadable instruction memory
package imem_pkg;

   localparam int IMEM_DATA_W = 32;
   localparam int IMEM_DEPTH  = 64;

   localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x DATA_W storage, one write port, one registered read port
module imem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   // No reset on the storage; readability is controlled by the loaded count upstream.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - programmable instruction memory with fault-checked fetch port
module instr_mem_loadable
   import imem_pkg::*;
#(
   parameter int                 DATA_W   = IMEM_DATA_W,
   parameter int                 DEPTH    = IMEM_DEPTH,
   parameter int                 ADDR_W   = 32,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(IMEM_NOP_WORD),
   parameter int                 CW       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   input  logic              load_done,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              addr_fault,
   output logic [CW-1:0]     loaded_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int XW = ADDR_W + CW;

   imem_state_t       state, state_nxt;
   logic              wr_en;
   logic              fetch_fire;
   logic              fetch_fault;
   logic [XW-1:0]     idx_x;
   logic              fault_q;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] resp_word;
   logic [DATA_W-1:0] last_instr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load_start) state_nxt = LOAD;
         LOAD: begin
            if (load_start)     state_nxt = LOAD;
            else if (load_done) state_nxt = RUN;
         end
         RUN:  if (load_start) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_ready  = (state == LOAD) && (loaded_count < CW'(DEPTH)) && !load_start;
      fetch_ready = (state == RUN) && !load_start;
   end

   // Writes and reads are gated by rst_n so a reset edge never lands a load word or a fetch.
   assign wr_en      = rst_n && load_valid && load_ready;
   assign fetch_fire = rst_n && fetch_valid && fetch_ready;

   assign idx_x       = XW'(fetch_addr >> 2);
   assign fetch_fault = (fetch_addr[1:0] != 2'b00)
                     || (idx_x >= XW'(DEPTH))
                     || (idx_x >= XW'(loaded_count));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loaded_count <= '0;
      end else if (load_start) begin
         loaded_count <= '0;
      end else if (wr_en) begin
         loaded_count <= loaded_count + CW'(1);
      end
   end

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (loaded_count[AW-1:0]),
      .wr_data (load_data),
      .rd_en   (fetch_fire),
      .rd_addr (idx_x[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_valid <= 1'b0;
         fault_q     <= 1'b0;
         last_instr  <= '0;
      end else begin
         instr_valid <= fetch_fire;
         if (fetch_fire) begin
            fault_q <= fetch_fault;
         end
         if (instr_valid) begin
            last_instr <= resp_word;
         end
      end
   end

   // The array's read register is not reset, so the held value comes from last_instr.
   assign resp_word   = fault_q ? NOP_WORD : rd_data;
   assign instruction = instr_valid ? resp_word : last_instr;
   assign addr_fault  = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - directed self-checking bench for instr_mem_loadable
module tb_instr_mem_loadable;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 64;
   localparam int          ADDR_W = 32;
   localparam int          CW     = 7;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk;
   logic              rst_n;
   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_done;
   logic              fetch_valid;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instruction;
   logic              addr_fault;
   logic [CW-1:0]     loaded_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] prog [10] = '{
      32'h0010_0093, 32'h0011_2023, 32'h0020_0113, 32'h0021_2223, 32'h0030_0193,
      32'h0031_2423, 32'h0040_0213, 32'h0041_2623, 32'h0050_0293, 32'h0051_2823
   };

   instr_mem_loadable #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .NOP_WORD (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .load_done    (load_done),
      .fetch_valid  (fetch_valid),
      .fetch_addr   (fetch_addr),
      .fetch_ready  (fetch_ready),
      .instr_valid  (instr_valid),
      .instruction  (instruction),
      .addr_fault   (addr_fault),
      .loaded_count (loaded_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] d, input logic done);
      load_valid = 1'b1;
      load_data  = d;
      load_done  = done;
      tick();
      load_valid = 1'b0;
      load_done  = 1'b0;
   endtask

   task automatic fetch_one(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_word, input logic exp_fault);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      #1;
      check({tag, "_ready"}, 64'(fetch_ready), 64'd1);
      tick();
      fetch_valid = 1'b0;
      check({tag, "_valid"}, 64'(instr_valid), 64'd1);
      check({tag, "_word"},  64'(instruction), 64'(exp_word));
      check({tag, "_fault"}, 64'(addr_fault),  64'(exp_fault));
      tick();
      check({tag, "_once"},  64'(instr_valid), 64'd0);
      check({tag, "_hold"},  64'(instruction), 64'(exp_word));
   endtask

   initial begin
      rst_n       = 1'b0;
      load_start  = 1'b0;
      load_valid  = 1'b0;
      load_data   = '0;
      load_done   = 1'b0;
      fetch_valid = 1'b0;
      fetch_addr  = '0;
      tick();
      tick();
      check("rst_valid", 64'(instr_valid),  64'd0);
      check("rst_instr", 64'(instruction),  64'd0);
      check("rst_fault", 64'(addr_fault),   64'd0);
      check("rst_count", 64'(loaded_count), 64'd0);
      check("rst_lrdy",  64'(load_ready),   64'd0);
      check("rst_frdy",  64'(fetch_ready),  64'd0);
      rst_n = 1'b1;

      // Program ten words and stream them back.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      #1;
      check("load_rdy", 64'(load_ready),   64'd1);
      check("load_cnt0", 64'(loaded_count), 64'd0);
      for (int i = 0; i < 10; i++) load_word(prog[i], 1'b0);
      check("cnt10", 64'(loaded_count), 64'd10);
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      #1;
      check("run_frdy", 64'(fetch_ready), 64'd1);
      check("run_lrdy", 64'(load_ready),  64'd0);

      fetch_valid = 1'b1;
      fetch_addr  = '0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("b2b_valid", 64'(instr_valid), 64'd1);
         check("b2b_word",  64'(instruction), 64'(prog[k-1]));
         check("b2b_fault", 64'(addr_fault),  64'd0);
         if (k < 10) fetch_addr = 32'(4 * k);
         else        fetch_valid = 1'b0;
      end
      tick();
      check("b2b_end",  64'(instr_valid), 64'd0);
      check("b2b_hold", 64'(instruction), 64'(prog[9]));

      fetch_one("f40",  32'd40,  NOP,     1'b1);
      fetch_one("f2",   32'd2,   NOP,     1'b1);
      fetch_one("f256", 32'd256, NOP,     1'b1);
      fetch_one("f36",  32'd36,  prog[9], 1'b0);
      fetch_one("f4",   32'd4,   prog[1], 1'b0);

      // load_start collides with a fetch: the fetch must lose.
      fetch_valid = 1'b1;
      fetch_addr  = '0;
      load_start  = 1'b1;
      #1;
      check("coll_frdy", 64'(fetch_ready), 64'd0);
      check("coll_lrdy", 64'(load_ready),  64'd0);
      tick();
      fetch_valid = 1'b0;
      load_start  = 1'b0;
      #1;
      check("coll_valid", 64'(instr_valid),  64'd0);
      check("coll_cnt",   64'(loaded_count), 64'd0);
      check("coll_lrdy2", 64'(load_ready),   64'd1);
      check("coll_frdy2", 64'(fetch_ready),  64'd0);

      // Fill to capacity, then push past it.
      for (int i = 0; i < 64; i++) load_word(32'hA000_0000 | 32'(i), 1'b0);
      check("cnt64",     64'(loaded_count), 64'd64);
      for (int j = 0; j < 3; j++) begin
         load_valid = 1'b1;
         load_data  = 32'hDEAD_BEEF;
         #1;
         check("full_lrdy", 64'(load_ready), 64'd0);
         tick();
         check("full_cnt", 64'(loaded_count), 64'd64);
      end
      load_valid = 1'b0;
      load_done  = 1'b1;
      tick();
      load_done  = 1'b0;
      fetch_one("full0",   32'd0,   32'hA000_0000, 1'b0);
      fetch_one("full252", 32'd252, 32'hA000_003F, 1'b0);
      fetch_one("full256", 32'd256, NOP,           1'b1);
      fetch_one("full254", 32'd254, NOP,           1'b1);

      // Restart within LOAD, then reset mid-load.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_word(32'hB100_0000, 1'b0);
      load_word(32'hB100_0001, 1'b0);
      check("rel_cnt2", 64'(loaded_count), 64'd2);
      load_start = 1'b1;
      #1;
      check("rel_lrdy", 64'(load_ready), 64'd0);
      tick();
      load_start = 1'b0;
      check("rel_cnt0", 64'(loaded_count), 64'd0);
      for (int i = 0; i < 5; i++) load_word(32'hB000_0000 | 32'(i), 1'b0);
      check("cnt5", 64'(loaded_count), 64'd5);
      rst_n      = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'hFFFF_FFFF;
      tick();
      rst_n      = 1'b1;
      load_valid = 1'b0;
      #1;
      check("mrst_cnt",  64'(loaded_count), 64'd0);
      check("mrst_lrdy", 64'(load_ready),   64'd0);
      check("mrst_frdy", 64'(fetch_ready),  64'd0);
      fetch_valid = 1'b1;
      fetch_addr  = '0;
      tick();
      check("idle_fetch1", 64'(instr_valid), 64'd0);
      tick();
      check("idle_fetch2", 64'(instr_valid), 64'd0);
      fetch_valid = 1'b0;

      // Reload with the final word and load_done in the same cycle.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_word(32'hC000_0000, 1'b0);
      load_word(32'hC000_0001, 1'b0);
      load_word(32'hC000_0002, 1'b1);
      check("cnt3", 64'(loaded_count), 64'd3);
      fetch_one("rl8",  32'd8,  32'hC000_0002, 1'b0);
      fetch_one("rl12", 32'd12, NOP,           1'b1);
      fetch_one("rl0",  32'd0,  32'hC000_0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
